rgbw_pwm_generator: RTL and testbench
=====================================

Name: rgbw_pwm_generator

Overview:
- Downstream consumer of the clock prescaler. It uses the prescaler's divided pulse as a count enable and the prescaler's release signal as a run gate.
- Generates four independent 8-bit PWM outputs for the R, G, B and W channels.
- Duty values from the colour front-end are double-buffered. They take effect only on a period boundary, so no glitched or partial periods reach the LED drivers.

Parameters:
- CW, 8: counter and duty width in bits.
- PERIOD_MAX, 254: terminal count. Period is PERIOD_MAX+1 = 255 ticks, so duty 0 means always off and duty 255 means always on.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  driven by the prescaler's reset_out. Low holds the block idle.
- tick  in  1  prescaler pulse; one-clock-wide count enable.
- duty_r  in  CW  red duty request.
- duty_g  in  CW  green duty request.
- duty_b  in  CW  blue duty request.
- duty_w  in  CW  white duty request.
- duty_valid  in  1  one-clock strobe that captures all four duty_* inputs.
- pwm_out  out  4  registered PWM outputs, bit order {w,b,g,r}.
- period_start  out  1  one-clock pulse in the cycle after the counter wraps to 0.
- update_pending  out  1  high while captured duties are waiting for the next boundary.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - reset is synchronous and active-high. Port names are clk and reset.
- Reset values:
  - cnt=0, active duties=0, pending duties=0.
  - pwm_out=4'b0000, period_start=0, update_pending=0, state=IDLE.
- State machine:
  - IDLE → RUN when run=1. On this transition:
    - cnt is cleared to 0.
    - If update_pending=1, pending is copied to active and update_pending is cleared.
    - period_start pulses in the following cycle.
  - RUN → IDLE when run=0. Takes effect next clock: cnt=0 and pwm_out=0. Pending and active duties are retained.
- Counter:
  - Advances only in RUN on clocks where tick=1.
  - cnt==PERIOD_MAX with tick → cnt=0. This is the wrap event.
  - tick=0 → cnt holds.
  - tick is ignored in IDLE.
- Output:
  - pwm_out[i] <= (cnt_next < active_i), computed with the post-update counter value and post-update active duty.
  - pwm_out changes in the same clock edge that the counter updates. Latency from the tick cycle is 1 clock.
  - Duty 0 → never high. Duty 255 → always high (cnt never exceeds 254).
- Double buffering:
  - duty_valid=1 → all four inputs latch into pending and update_pending=1.
  - At wrap, if update_pending=1: pending copies to active and update_pending clears.
  - duty_valid in the same cycle as a wrap: the new inputs go straight to active (bypass), pending is also loaded with them, and update_pending=0.
  - A second duty_valid before a boundary overwrites pending; the last write wins.
- period_start: registered. Asserted for one clock after every wrap and after every IDLE→RUN entry.
- Tick timing: tick is high for at most one clock in any 4 clocks, so one period is 1020 clocks. The block must not depend on the tick spacing.
- reset asserted mid-period: all outputs go to their reset values on the next edge. reset overrides run, tick and duty_valid.

Decomposition:
- Shared package (rgbw_pkg):
  - CW and PERIOD_MAX.
  - State encodings ST_IDLE=1'b0 and ST_RUN=1'b1.
  - Channel index constants CH_R=0, CH_G=1, CH_B=2, CH_W=3.
- One natural sub-module: pwm_channel. It holds the pending and active registers for one channel plus the comparator and output flop. It is instantiated four times with shared cnt_next, load_pending and commit strobes.
- The top level holds the FSM, the counter, update_pending and period_start.

Test Plan:
1. Reset, then run=1, duties r=0, g=255, b=128, w=1 loaded during IDLE:
   - First period: r never high, g always high.
   - b high for 128 ticks (512 clocks), w high for 1 tick.
   - period_start pulses every 1020 clocks.
2. Running at r=64, duty_valid with r=200 mid-period:
   - r keeps 64 ticks of high for the rest of that period.
   - update_pending=1 until the wrap, then the next period is 200 ticks high and update_pending=0.
3. duty_valid with r=10 in the exact wrap cycle:
   - The new period immediately shows 10 ticks high.
   - update_pending stays 0.
4. Two duty_valid strobes in one period (r=30 then r=90):
   - The next period uses 90.
5. run drops mid-period with cnt=100:
   - Next clock: pwm_out=0 and cnt=0.
   - run reasserted: counting restarts from 0, period_start pulses, duties are retained.
6. reset=1 for one clock at cnt=200 with r=255:
   - pwm_out=0, update_pending=0 and state=IDLE.
   - No output activity until run=1.

Source files
------------

// File: rtl/rgbw_pkg.sv
// Shared constants and state encoding for the RGBW PWM generator.
package rgbw_pkg;
   localparam int CW         = 8;
   localparam int PERIOD_MAX = 254;
   localparam int NUM_LANES  = 4;

   localparam int CH_R = 0;
   localparam int CH_G = 1;
   localparam int CH_B = 2;
   localparam int CH_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/rgbw_pwm_generator_channel.sv
// One PWM lane: pending/active duty registers, comparator and output flop.
module pwm_channel #(
   parameter int CW = rgbw_pkg::CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_pending,
   input  logic          commit,
   input  logic          out_en,
   input  logic [CW-1:0] duty_in,
   input  logic [CW-1:0] cnt_next,
   output logic          pwm
);
   logic [CW-1:0] pending;
   logic [CW-1:0] active;
   logic [CW-1:0] active_next;

   // A load coinciding with a commit bypasses pending straight into active.
   always_comb begin
      active_next = active;
      if (commit) active_next = load_pending ? duty_in : pending;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
         active  <= '0;
         pwm     <= 1'b0;
      end else begin
         if (load_pending) pending <= duty_in;
         active <= active_next;
         pwm    <= out_en && (cnt_next < active_next);
      end
   end
endmodule

// File: rtl/rgbw_pwm_generator.sv
// Four-channel 8-bit PWM with double-buffered duties committed on period boundaries.
module rgbw_pwm_generator #(
   parameter int CW         = rgbw_pkg::CW,
   parameter int PERIOD_MAX = rgbw_pkg::PERIOD_MAX
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          tick,
   input  logic [CW-1:0] duty_r,
   input  logic [CW-1:0] duty_g,
   input  logic [CW-1:0] duty_b,
   input  logic [CW-1:0] duty_w,
   input  logic          duty_valid,
   output logic [3:0]    pwm_out,
   output logic          period_start,
   output logic          update_pending
);
   import rgbw_pkg::*;

   state_t                       state;
   logic [CW-1:0]                cnt;
   logic [CW-1:0]                cnt_next;
   logic [NUM_LANES-1:0][CW-1:0] duty_in;
   logic                         enter;
   logic                         wrap;
   logic                         boundary;
   logic                         commit;

   always_comb begin
      duty_in       = '0;
      duty_in[CH_R] = duty_r;
      duty_in[CH_G] = duty_g;
      duty_in[CH_B] = duty_b;
      duty_in[CH_W] = duty_w;
   end

   // IDLE->RUN entry is treated as a boundary just like a wrap.
   assign enter    = (state == ST_IDLE) && run;
   assign wrap     = (state == ST_RUN) && run && tick && (cnt == CW'(PERIOD_MAX));
   assign boundary = enter || wrap;
   assign commit   = boundary && (update_pending || duty_valid);

   always_comb begin
      cnt_next = '0;
      if (state == ST_RUN && run) begin
         if (tick) cnt_next = (cnt == CW'(PERIOD_MAX)) ? '0 : cnt + 1'b1;
         else      cnt_next = cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         period_start   <= 1'b0;
         update_pending <= 1'b0;
      end else begin
         cnt          <= cnt_next;
         period_start <= boundary;
         if (boundary)        update_pending <= 1'b0;
         else if (duty_valid) update_pending <= 1'b1;
         case (state)
            ST_IDLE: if (run)  state <= ST_RUN;
            ST_RUN:  if (!run) state <= ST_IDLE;
            default:           state <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_ch
      pwm_channel #(.CW(CW)) u_ch (
         .clk          (clk),
         .reset        (reset),
         .load_pending (duty_valid),
         .commit       (commit),
         .out_en       (run),
         .duty_in      (duty_in[i]),
         .cnt_next     (cnt_next),
         .pwm          (pwm_out[i])
      );
   end
endmodule

// File: tb/tb_rgbw_pwm_generator.sv
// Directed bench: measures high-time per channel over whole PWM periods.
module tb_rgbw_pwm_generator;
   logic       clk = 1'b0;
   logic       reset, run, tick, duty_valid;
   logic [7:0] duty_r, duty_g, duty_b, duty_w;
   logic [3:0] pwm_out;
   logic       period_start, update_pending;

   int checks = 0;
   int errors = 0;
   int hi [4];
   int ps_cnt;

   always #5 clk = ~clk;

   rgbw_pwm_generator dut (
      .clk            (clk),
      .reset          (reset),
      .run            (run),
      .tick           (tick),
      .duty_r         (duty_r),
      .duty_g         (duty_g),
      .duty_b         (duty_b),
      .duty_w         (duty_w),
      .duty_valid     (duty_valid),
      .pwm_out        (pwm_out),
      .period_start   (period_start),
      .update_pending (update_pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 4; i++) hi[i] = 0;
      ps_cnt = 0;
   endtask

   task automatic sample();
      for (int i = 0; i < 4; i++) if (pwm_out[i]) hi[i]++;
      if (period_start) ps_cnt++;
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   // One tick slot: tick high for one clock, then three quiet clocks.
   task automatic do_tick(input bit dv);
      tick = 1'b1;
      duty_valid = dv;
      clk1();
      tick = 1'b0;
      duty_valid = 1'b0;
      sample();
      repeat (3) begin
         clk1();
         sample();
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) do_tick(1'b0);
   endtask

   task automatic strobe();
      duty_valid = 1'b1;
      clk1();
      duty_valid = 1'b0;
   endtask

   task automatic chk_win(input string tag, input int er, input int eg, input int eb,
                          input int ew, input int eps);
      chk({tag, "_r"},  hi[0], er);
      chk({tag, "_g"},  hi[1], eg);
      chk({tag, "_b"},  hi[2], eb);
      chk({tag, "_w"},  hi[3], ew);
      chk({tag, "_ps"}, ps_cnt, eps);
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; tick = 1'b0; duty_valid = 1'b0;
      duty_r = 8'd0; duty_g = 8'd0; duty_b = 8'd0; duty_w = 8'd0;
      clr();
      repeat (2) clk1();
      chk("rst_pwm", pwm_out, 4'b0000);
      chk("rst_ps", period_start, 1'b0);
      chk("rst_up", update_pending, 1'b0);
      reset = 1'b0;

      // 1: load in IDLE, then run
      duty_r = 8'd0; duty_g = 8'd255; duty_b = 8'd128; duty_w = 8'd1;
      strobe();
      chk("t1_up_idle", update_pending, 1'b1);
      clr();
      ticks(2);
      chk_win("t1_idle", 0, 0, 0, 0, 0);
      clr();
      run = 1'b1;
      clk1();
      sample();
      chk("t1_entry_ps", period_start, 1'b1);
      repeat (3) begin clk1(); sample(); end
      ticks(254);
      chk_win("t1_p0", 0, 1020, 512, 4, 1);
      chk("t1_up_run", update_pending, 1'b0);
      clr();
      ticks(255);
      chk_win("t1_p1", 0, 1020, 512, 4, 1);

      // 2: r=64 running, mid-period request for 200
      duty_r = 8'd64;
      strobe();
      clr();
      ticks(100);
      duty_r = 8'd200;
      do_tick(1'b1);
      chk("t2_up_mid", update_pending, 1'b1);
      ticks(154);
      chk_win("t2_p64", 256, 1020, 512, 4, 1);
      chk("t2_up_end", update_pending, 1'b1);
      clr();
      ticks(255);
      chk_win("t2_p200", 800, 1020, 512, 4, 1);
      chk("t2_up_after", update_pending, 1'b0);

      // 3: request in the exact wrap cycle bypasses to active
      duty_r = 8'd10;
      clr();
      do_tick(1'b1);
      chk("t3_up_wrap", update_pending, 1'b0);
      ticks(254);
      chk_win("t3_p10", 40, 1020, 512, 4, 1);

      // 4: two requests in one period, last one wins
      clr();
      ticks(50);
      duty_r = 8'd30;
      do_tick(1'b1);
      ticks(50);
      duty_r = 8'd90;
      do_tick(1'b1);
      ticks(153);
      chk_win("t4_p10", 40, 1020, 512, 4, 1);
      chk("t4_up", update_pending, 1'b1);
      clr();
      ticks(255);
      chk_win("t4_p90", 360, 1020, 512, 4, 1);

      // 5: run drops at cnt=100, then restarts from 0
      ticks(101);
      chk("t5_pwm_c100", pwm_out, 4'b0110);
      run = 1'b0;
      clk1();
      chk("t5_pwm_drop", pwm_out, 4'b0000);
      clr();
      ticks(2);
      chk_win("t5_idle", 0, 0, 0, 0, 0);
      run = 1'b1;
      clk1();
      chk("t5_pwm_c0", pwm_out, 4'b1111);
      chk("t5_entry_ps", period_start, 1'b1);
      repeat (3) clk1();
      do_tick(1'b0);
      chk("t5_pwm_c1", pwm_out, 4'b0111);
      chk("t5_ps_c1", period_start, 1'b0);

      // 6: reset mid-period at cnt=200 with r=255
      duty_r = 8'd255;
      do_tick(1'b1);
      ticks(252);
      ticks(1);
      ticks(199);
      do_tick(1'b1);
      chk("t6_pwm_c200", pwm_out, 4'b0011);
      chk("t6_up_pre", update_pending, 1'b1);
      reset = 1'b1;
      run = 1'b0;
      clk1();
      reset = 1'b0;
      chk("t6_rst_pwm", pwm_out, 4'b0000);
      chk("t6_rst_up", update_pending, 1'b0);
      chk("t6_rst_ps", period_start, 1'b0);
      clr();
      ticks(3);
      chk_win("t6_idle", 0, 0, 0, 0, 0);
      run = 1'b1;
      clk1();
      chk("t6_entry_ps", period_start, 1'b1);
      chk("t6_entry_pwm", pwm_out, 4'b0000);
      clr();
      ticks(10);
      chk_win("t6_run", 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
